cache_set_nway: RTL and testbench

Parametrised N-way cache set for the L1 caches: holds WAYS lines of one set, each with tag, valid, dirty and LINE_WORDS data words, and keeps a tree pseudo-LRU. Serves single-word read/write lookups with one-cycle registered response. Runs its own evict-then-refill sequence toward the AXI-facing cache controller. Replaces single-line block instances; one instance per set index, or per index slice, under the controller.

---
 rtl/cache_pkg.sv | 28 ++
 rtl/cache_plru_tree.sv | 49 ++++
 rtl/cache_set_nway.sv | 167 ++++++++++++++++
 tb/tb_cache_set_nway.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache set: the FSM encoding, the line-size derivation
// and the tree pseudo-LRU victim walk.
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVICT = 2'd1,
        ST_FILL  = 2'd2
    } state_t;

    function automatic int line_words(input int offset_width);
        return 1 << offset_width;
    endfunction

    // Heap-ordered tree: node n has children 2n+1 (bit=0) and 2n+2 (bit=1).
    // Supports up to 8 ways (7 nodes); unused upper nodes are ignored.
    function automatic logic [2:0] plru_victim(input logic [6:0] tree, input int ways);
        logic [2:0] node;
        node = 3'd0;
        for (int l = 0; l < 3; l++) begin
            if ((1 << l) < ways) begin
                node = {node[1:0], 1'b0} + 3'd1 + {2'b00, tree[node]};
            end
        end
        return node - 3'(ways - 1);
    endfunction

endpackage

// File: rtl/cache_plru_tree.sv
// Tree pseudo-LRU state for one cache set: an access makes every node on its
// path point away from the accessed way; the victim is found by following the bits.
module cache_plru_tree
    import cache_pkg::*;
#(
    parameter int WAYS  = 4,
    parameter int IDX_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             update,
    input  logic [IDX_W-1:0] way,
    output logic [IDX_W-1:0] victim
);

    // Nodes at or beyond WAYS-1 are never on an update path and stay zero.
    logic [6:0] tree_q;
    logic [6:0] tree_nxt;
    logic [2:0] node;
    logic       dir;
    logic [2:0] victim_full;

    // NOTE: combinational blocks use blocking '=' so later statements see the
    // updated value; every output gets a default first so no latch is inferred.
    always_comb begin
        tree_nxt = tree_q;
        node     = 3'd0;
        dir      = 1'b0;
        for (int l = 0; l < IDX_W; l++) begin
            dir            = way[IDX_W-1-l];
            tree_nxt[node] = ~dir;
            node           = {node[1:0], 1'b0} + 3'd1 + {2'b00, dir};
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so all registers sample
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tree_q <= '0;
        end else if (update) begin
            tree_q <= tree_nxt;
        end
    end

    assign victim_full = plru_victim(tree_q, WAYS);
    assign victim      = IDX_W'(victim_full);

endmodule

// File: rtl/cache_set_nway.sv
// One N-way cache set: single-word lookups with a registered response, plus an
// evict-then-refill sequence driven by the cache controller.
module cache_set_nway
    import cache_pkg::*;
#(
    parameter int WAYS         = 4,
    parameter int TAG_WIDTH    = 20,
    parameter int OFFSET_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [TAG_WIDTH-1:0]    req_tag,
    input  logic [OFFSET_WIDTH-1:0] req_off,
    input  logic [3:0]              req_be,
    input  logic [31:0]             req_wdata,
    output logic                    resp_valid,
    output logic                    resp_hit,
    output logic [31:0]             resp_rdata,
    input  logic                    fill_start,
    input  logic [TAG_WIDTH-1:0]    fill_tag,
    input  logic                    fill_wvalid,
    input  logic [31:0]             fill_wdata,
    output logic                    evict_valid,
    input  logic                    evict_ready,
    output logic [TAG_WIDTH-1:0]    evict_tag,
    output logic [31:0]             evict_data,
    output logic                    fill_done,
    input  logic                    flush
);

    localparam int IDX_W      = $clog2(WAYS);
    localparam int LINE_WORDS = line_words(OFFSET_WIDTH);

    state_t                    state_q, state_nxt;
    logic [TAG_WIDTH-1:0]      tag_q [WAYS];
    logic [31:0]               data_q [WAYS][LINE_WORDS];
    logic [WAYS-1:0]           valid_q, dirty_q;
    logic [OFFSET_WIDTH-1:0]   cnt_q;
    logic [IDX_W-1:0]          victim_q;
    logic [TAG_WIDTH-1:0]      fill_tag_q;

    logic             hit;
    logic [IDX_W-1:0] hit_way, victim, plru_vict, plru_way;
    logic             idle, flush_go, start_go, lookup_go, write_hit;
    logic             evict_beat, fill_beat, cnt_last, plru_update;

    assign idle        = (state_q == ST_IDLE);
    assign flush_go    = idle & flush;
    assign start_go    = idle & ~flush & fill_start;
    assign lookup_go   = idle & ~flush & ~fill_start & req_valid;
    assign write_hit   = lookup_go & hit & req_we;
    assign cnt_last    = (cnt_q == OFFSET_WIDTH'(LINE_WORDS - 1));
    assign evict_beat  = (state_q == ST_EVICT) & evict_ready;
    assign fill_beat   = (state_q == ST_FILL) & fill_wvalid;
    assign plru_update = (lookup_go & hit) | (fill_beat & cnt_last);
    assign plru_way    = (state_q == ST_FILL) ? victim_q : hit_way;

    // Descending scan so the lowest matching / lowest invalid way wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        victim  = plru_vict;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[w] && tag_q[w] == req_tag) begin
                hit     = 1'b1;
                hit_way = IDX_W'(w);
            end
            if (!valid_q[w]) begin
                victim = IDX_W'(w);
            end
        end
    end

    cache_plru_tree #(.WAYS(WAYS)) u_plru (
        .clk    (clk),
        .rst    (rst),
        .update (plru_update),
        .way    (plru_way),
        .victim (plru_vict)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_go) begin
                    state_nxt = (valid_q[victim] && dirty_q[victim]) ? ST_EVICT : ST_FILL;
                end
            end
            ST_EVICT: if (evict_beat && cnt_last) state_nxt = ST_FILL;
            ST_FILL:  if (fill_beat && cnt_last)  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready   = idle;
        evict_valid = (state_q == ST_EVICT);
        evict_data  = evict_valid ? data_q[victim_q][cnt_q] : 32'd0;
        fill_done   = fill_beat & cnt_last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= '0;
            dirty_q    <= '0;
            cnt_q      <= '0;
            victim_q   <= '0;
            fill_tag_q <= '0;
            evict_tag  <= '0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_rdata <= '0;
            for (int w = 0; w < WAYS; w++) tag_q[w] <= '0;
        end else begin
            resp_valid <= lookup_go;
            resp_hit   <= lookup_go & hit;
            resp_rdata <= (lookup_go && hit && !req_we) ? data_q[hit_way][req_off] : 32'd0;
            if (flush_go) begin
                valid_q <= '0;
                dirty_q <= '0;
            end
            if (start_go) begin
                victim_q   <= victim;
                fill_tag_q <= fill_tag;
                evict_tag  <= tag_q[victim];
                cnt_q      <= '0;
            end
            if (write_hit) dirty_q[hit_way] <= 1'b1;
            if (evict_beat) begin
                cnt_q <= cnt_last ? '0 : cnt_q + 1'b1;
                if (cnt_last) valid_q[victim_q] <= 1'b0;
            end
            if (fill_beat) begin
                cnt_q <= cnt_last ? '0 : cnt_q + 1'b1;
                if (cnt_last) begin
                    tag_q[victim_q]   <= fill_tag_q;
                    valid_q[victim_q] <= 1'b1;
                    dirty_q[victim_q] <= 1'b0;
                end
            end
        end
    end

    // NOTE: the data array has no reset; a line's contents only matter once its
    // valid bit is set, and valid bits are reset above.
    always_ff @(posedge clk) begin
        if (write_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (req_be[b]) data_q[hit_way][req_off][8*b +: 8] <= req_wdata[8*b +: 8];
            end
        end
        if (fill_beat) data_q[victim_q][cnt_q] <= fill_wdata;
    end

endmodule

// File: tb/tb_cache_set_nway.sv
// Directed bench for cache_set_nway (WAYS=4, 20-bit tag, 16-word lines).
module tb_cache_set_nway;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 0, req_we = 0;
    logic        req_ready;
    logic [19:0] req_tag = '0;
    logic [3:0]  req_off = '0, req_be = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid, resp_hit;
    logic [31:0] resp_rdata;
    logic        fill_start = 0, fill_wvalid = 0, evict_ready = 0, flush = 0;
    logic [19:0] fill_tag = '0;
    logic [31:0] fill_wdata = '0;
    logic        evict_valid, fill_done;
    logic [19:0] evict_tag;
    logic [31:0] evict_data;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    cache_set_nway #(.WAYS(4), .TAG_WIDTH(20), .OFFSET_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_tag(req_tag), .req_off(req_off), .req_be(req_be), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_rdata(resp_rdata),
        .fill_start(fill_start), .fill_tag(fill_tag), .fill_wvalid(fill_wvalid),
        .fill_wdata(fill_wdata), .evict_valid(evict_valid), .evict_ready(evict_ready),
        .evict_tag(evict_tag), .evict_data(evict_data), .fill_done(fill_done), .flush(flush)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic we, input logic [19:0] tag, input logic [3:0] off,
                          input logic [3:0] be, input logic [31:0] wd,
                          output logic v, output logic h, output logic [31:0] rd);
        req_valid = 1'b1; req_we = we; req_tag = tag; req_off = off; req_be = be; req_wdata = wd;
        step();
        v = resp_valid; h = resp_hit; rd = resp_rdata;
        req_valid = 1'b0; req_we = 1'b0;
    endtask

    task automatic fill_words(input logic [31:0] base, output int done_at, output int done_cnt,
                              output int evict_cycles);
        done_at = -1; done_cnt = 0; evict_cycles = 0;
        for (int k = 0; k < 16; k++) begin
            fill_wvalid = 1'b1;
            fill_wdata  = base + 32'(k);
            #1;
            if (fill_done) begin done_at = k; done_cnt++; end
            if (evict_valid) evict_cycles++;
            step();
        end
        fill_wvalid = 1'b0;
    endtask

    task automatic fill_line(input logic [19:0] tag, input logic [31:0] base,
                             output int done_at, output int done_cnt, output int evict_cycles);
        fill_start = 1'b1; fill_tag = tag;
        step();
        fill_start = 1'b0;
        fill_words(base, done_at, done_cnt, evict_cycles);
    endtask

    task automatic test_reset();
        logic v, h; logic [31:0] rd;
        rst = 1'b1;
        repeat (3) step();
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b expected 1", req_ready); else pass_cnt++;
        total_cnt++; if ({resp_valid, resp_hit, evict_valid, fill_done} !== 4'b0000)
            $display("FAIL reset_flags: got %b expected 0000", {resp_valid, resp_hit, evict_valid, fill_done}); else pass_cnt++;
        total_cnt++; if ({resp_rdata, evict_data, evict_tag} !== 84'd0)
            $display("FAIL reset_data: got %h expected 0", {resp_rdata, evict_data, evict_tag}); else pass_cnt++;
        rst = 1'b0;
        step();
        lookup(1'b0, 20'h12345, 4'd3, 4'h0, 32'h0, v, h, rd);
        total_cnt++; if ({v, h} !== 2'b10) $display("FAIL reset_lookup_vh: got %b expected 10", {v, h}); else pass_cnt++;
        total_cnt++; if (rd !== 32'd0) $display("FAIL reset_lookup_rdata: got %h expected 0", rd); else pass_cnt++;
    endtask

    task automatic test_fill_no_evict();
        logic v, h; logic [31:0] rd; int da, dc, ec;
        fill_start = 1'b1; fill_tag = 20'hABCDE;
        step();
        fill_start = 1'b0;
        total_cnt++; if (req_ready !== 1'b0) $display("FAIL fill_req_ready_low: got %b expected 0", req_ready); else pass_cnt++;
        fill_words(32'h100, da, dc, ec);
        total_cnt++; if (da !== 15 || dc !== 1) $display("FAIL fill_done_pulse: got at %0d count %0d expected at 15 count 1", da, dc); else pass_cnt++;
        total_cnt++; if (ec !== 0) $display("FAIL fill_no_evict: got %0d evict cycles expected 0", ec); else pass_cnt++;
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL fill_req_ready_back: got %b expected 1", req_ready); else pass_cnt++;
        lookup(1'b0, 20'hABCDE, 4'd5, 4'h0, 32'h0, v, h, rd);
        total_cnt++; if ({v, h, rd} !== {2'b11, 32'h105}) $display("FAIL fill_read5: got %b%b %h expected 11 00000105", v, h, rd); else pass_cnt++;
        lookup(1'b0, 20'hABCDE, 4'd15, 4'h0, 32'h0, v, h, rd);
        total_cnt++; if ({v, h, rd} !== {2'b11, 32'h10F}) $display("FAIL fill_read15: got %b%b %h expected 11 0000010f", v, h, rd); else pass_cnt++;
    endtask

    task automatic test_write_be();
        logic v, h; logic [31:0] rd;
        lookup(1'b1, 20'hABCDE, 4'd5, 4'b0011, 32'hFFFFFFFF, v, h, rd);
        total_cnt++; if ({v, h, rd} !== {2'b11, 32'h0}) $display("FAIL write_resp: got %b%b %h expected 11 00000000", v, h, rd); else pass_cnt++;
        lookup(1'b0, 20'hABCDE, 4'd5, 4'h0, 32'h0, v, h, rd);
        total_cnt++; if ({h, rd} !== {1'b1, 32'h0000FFFF}) $display("FAIL write_merge: got %b %h expected 1 0000ffff", h, rd); else pass_cnt++;
    endtask

    task automatic test_full_plru_evict();
        logic v, h; logic [31:0] rd; int da, dc, ec;
        logic [31:0] exp_word [16];
        int beat, cyc;
        for (int k = 0; k < 16; k++) exp_word[k] = 32'h100 + 32'(k);
        exp_word[5] = 32'h0000FFFF;
        fill_line(20'h11111, 32'h1100, da, dc, ec);
        fill_line(20'h22222, 32'h2200, da, dc, ec);
        fill_line(20'h33333, 32'h3300, da, dc, ec);
        total_cnt++; if (ec !== 0) $display("FAIL full_way3_no_evict: got %0d expected 0", ec); else pass_cnt++;
        lookup(1'b0, 20'h22222, 4'd2, 4'h0, 32'h0, v, h, rd);
        total_cnt++; if ({h, rd} !== {1'b1, 32'h2202}) $display("FAIL full_read_way2: got %b %h expected 1 00002202", h, rd); else pass_cnt++;
        // Tree after fills 0..3 and the way-2 read points at way 0 (dirty).
        fill_start = 1'b1; fill_tag = 20'h44444;
        step();
        fill_start = 1'b0;
        total_cnt++; if (evict_valid !== 1'b1) $display("FAIL evict_first_beat: got %b expected 1", evict_valid); else pass_cnt++;
        total_cnt++; if (evict_tag !== 20'hABCDE) $display("FAIL evict_tag: got %h expected abcde", evict_tag); else pass_cnt++;
        beat = 0; cyc = 0;
        while (beat < 16 && cyc < 200) begin
            evict_ready = (cyc % 2 == 1);
            #1;
            if (!evict_valid) begin
                total_cnt++;
                $display("FAIL evict_valid_drop: got 0 expected 1 at beat %0d", beat);
                break;
            end
            total_cnt++;
            if (evict_data !== exp_word[beat])
                $display("FAIL evict_data: got %h expected %h at beat %0d", evict_data, exp_word[beat], beat);
            else pass_cnt++;
            step();
            if (evict_ready) beat++;
            cyc++;
        end
        evict_ready = 1'b0;
        total_cnt++; if (beat !== 16) $display("FAIL evict_beats: got %0d expected 16", beat); else pass_cnt++;
        total_cnt++; if ({evict_valid, req_ready} !== 2'b00) $display("FAIL evict_to_fill: got %b expected 00", {evict_valid, req_ready}); else pass_cnt++;
        fill_words(32'h400, da, dc, ec);
        total_cnt++; if (da !== 15 || dc !== 1) $display("FAIL refill_done: got at %0d count %0d expected at 15 count 1", da, dc); else pass_cnt++;
        lookup(1'b0, 20'hABCDE, 4'd0, 4'h0, 32'h0, v, h, rd);
        total_cnt++; if (h !== 1'b0) $display("FAIL evicted_miss: got %b expected 0", h); else pass_cnt++;
        lookup(1'b0, 20'h44444, 4'd9, 4'h0, 32'h0, v, h, rd);
        total_cnt++; if ({h, rd} !== {1'b1, 32'h409}) $display("FAIL new_line_read: got %b %h expected 1 00000409", h, rd); else pass_cnt++;
        lookup(1'b0, 20'h33333, 4'd15, 4'h0, 32'h0, v, h, rd);
        total_cnt++; if ({h, rd} !== {1'b1, 32'h330F}) $display("FAIL way3_kept: got %b %h expected 1 0000330f", h, rd); else pass_cnt++;
    endtask

    task automatic test_priority_ignore();
        logic v, h; logic [31:0] rd; int da, dc, ec;
        flush = 1'b1; fill_start = 1'b1; fill_tag = 20'h55555;
        step();
        flush = 1'b0; fill_start = 1'b0;
        total_cnt++; if ({req_ready, evict_valid} !== 2'b10) $display("FAIL flush_prio_state: got %b expected 10", {req_ready, evict_valid}); else pass_cnt++;
        lookup(1'b0, 20'h22222, 4'd2, 4'h0, 32'h0, v, h, rd);
        total_cnt++; if ({v, h} !== 2'b10) $display("FAIL flush_invalidates: got %b expected 10", {v, h}); else pass_cnt++;
        fill_wvalid = 1'b1; fill_wdata = 32'hDEADBEEF;
        step();
        fill_wvalid = 1'b0;
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL wvalid_idle_ready: got %b expected 1", req_ready); else pass_cnt++;
        lookup(1'b0, 20'h55555, 4'd0, 4'h0, 32'h0, v, h, rd);
        total_cnt++; if (h !== 1'b0) $display("FAIL wvalid_idle_no_alloc: got %b expected 0", h); else pass_cnt++;
        fill_line(20'h66666, 32'h600, da, dc, ec);
        total_cnt++; if (da !== 15 || dc !== 1 || ec !== 0)
            $display("FAIL fill_after_flush: got at %0d count %0d evict %0d expected 15 1 0", da, dc, ec); else pass_cnt++;
        lookup(1'b0, 20'h66666, 4'd7, 4'h0, 32'h0, v, h, rd);
        total_cnt++; if ({h, rd} !== {1'b1, 32'h607}) $display("FAIL fill_after_flush_read: got %b %h expected 1 00000607", h, rd); else pass_cnt++;
    endtask

    task automatic test_rst_mid_fill();
        logic v, h; logic [31:0] rd; int da, dc, ec;
        fill_start = 1'b1; fill_tag = 20'h77777;
        step();
        fill_start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            fill_wvalid = 1'b1; fill_wdata = 32'h700 + 32'(k);
            step();
        end
        fill_wdata = 32'h707;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++; if ({req_ready, resp_valid, resp_hit, evict_valid, fill_done} !== 5'b10000)
            $display("FAIL rst_mid_fill_flags: got %b expected 10000", {req_ready, resp_valid, resp_hit, evict_valid, fill_done}); else pass_cnt++;
        total_cnt++; if ({resp_rdata, evict_data, evict_tag} !== 84'd0)
            $display("FAIL rst_mid_fill_data: got %h expected 0", {resp_rdata, evict_data, evict_tag}); else pass_cnt++;
        fill_wvalid = 1'b0;
        step();
        rst = 1'b0;
        lookup(1'b0, 20'h77777, 4'd0, 4'h0, 32'h0, v, h, rd);
        total_cnt++; if ({v, h} !== 2'b10) $display("FAIL rst_partial_miss: got %b expected 10", {v, h}); else pass_cnt++;
        lookup(1'b0, 20'h66666, 4'd0, 4'h0, 32'h0, v, h, rd);
        total_cnt++; if (h !== 1'b0) $display("FAIL rst_old_miss: got %b expected 0", h); else pass_cnt++;
        fill_line(20'h88888, 32'h800, da, dc, ec);
        total_cnt++; if (da !== 15 || dc !== 1 || ec !== 0)
            $display("FAIL fill_after_rst: got at %0d count %0d evict %0d expected 15 1 0", da, dc, ec); else pass_cnt++;
        lookup(1'b0, 20'h88888, 4'd15, 4'h0, 32'h0, v, h, rd);
        total_cnt++; if ({h, rd} !== {1'b1, 32'h80F}) $display("FAIL fill_after_rst_read: got %b %h expected 1 0000080f", h, rd); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_fill_no_evict();
        test_write_be();
        test_full_plru_evict();
        test_priority_ignore();
        test_rst_mid_fill();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
